// File: rtl/vp_mult_pkg.sv
// Shared constants, FSM state type and limb helpers for the variable-precision
// multiplier sequencer.
package vp_mult_pkg;

  localparam int LIMB_W    = 16;
  localparam int MAX_LIMBS = 3;
  localparam int OP_W      = LIMB_W * MAX_LIMBS;   // 48
  localparam int PROD_W    = 2 * LIMB_W;           // 32
  localparam int RES_W     = 2 * OP_W;             // 96

  localparam logic [1:0] MODE_16 = 2'd0;
  localparam logic [1:0] MODE_32 = 2'd1;
  localparam logic [1:0] MODE_48 = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Encoding 3 is treated as the widest precision.
  function automatic logic [1:0] mode_to_limbs(input logic [1:0] mode);
    case (mode)
      MODE_16: return 2'd1;
      MODE_32: return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [LIMB_W-1:0] limb_sel(input logic [OP_W-1:0] v,
                                                 input logic [1:0]      idx);
    case (idx)
      2'd0:    return v[0*LIMB_W +: LIMB_W];
      2'd1:    return v[1*LIMB_W +: LIMB_W];
      default: return v[2*LIMB_W +: LIMB_W];
    endcase
  endfunction

endpackage

// File: rtl/vp_mult_limb_sequencer_if.sv
// Operand-side and result-side valid/ready handshake bundle of the sequencer.
import vp_mult_pkg::*;

interface vp_mult_limb_sequencer_if;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [OP_W-1:0]  a;
  logic [OP_W-1:0]  b;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] result;

  modport master (
    output in_valid, mode, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, mode, a, b, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/vp_mult_limb_mul16.sv
// Registered unsigned 16x16 -> 32 multiplier; the single shared datapath
// multiplier of the sequencer. The product register holds while en is low.
import vp_mult_pkg::*;

module vp_mult_limb_mul16 (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [LIMB_W-1:0] x,
  input  logic [LIMB_W-1:0] y,
  output logic [PROD_W-1:0] p
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p <= '0;
    end else if (en) begin
      p <= PROD_W'(x) * PROD_W'(y);
    end
  end

endmodule

// File: rtl/vp_mult_limb_sequencer.sv
// Limb sequencer: feeds one limb pair per cycle to the shared 16x16 multiplier
// and shift-accumulates the partial products into a 96-bit result.
import vp_mult_pkg::*;

module vp_mult_limb_sequencer (
  input  logic                     clk,
  input  logic                     rst_n,
  vp_mult_limb_sequencer_if.slave  bus,
  output logic                     busy
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a_q, b_q;
  logic [1:0]        n_q;
  logic [1:0]        i_q, j_q;
  logic [2:0]        sh_q;
  logic              pvld_q;
  logic [RES_W-1:0]  acc_q;

  logic              mul_en;
  logic [LIMB_W-1:0] mul_x, mul_y;
  logic [PROD_W-1:0] prod_q;
  logic [RES_W-1:0]  addend;
  logic              last_i, last_j;
  logic              accept;

  vp_mult_limb_mul16 u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mul_en),
    .x     (mul_x),
    .y     (mul_y),
    .p     (prod_q)
  );

  assign mul_x  = limb_sel(a_q, i_q);
  assign mul_y  = limb_sel(b_q, j_q);
  assign last_i = (i_q == n_q - 2'd1);
  assign last_j = (j_q == n_q - 2'd1);
  // Partial product weight is 2^(16*(i+j)); the largest shift (64) still fits in 96 bits.
  assign addend = {{(RES_W-PROD_W){1'b0}}, prod_q} << (LIMB_W * sh_q);

  // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    mul_en        = 1'b0;
    accept        = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        mul_en = 1'b1;
        if (last_i && last_j) state_d = FLUSH;
      end
      FLUSH: state_d = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.result = acc_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: operand copies are reset along with the control state so a reset leaves no stale transaction data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      n_q    <= 2'd1;
      i_q    <= '0;
      j_q    <= '0;
      sh_q   <= '0;
      pvld_q <= 1'b0;
      acc_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_q    <= bus.a;
            b_q    <= bus.b;
            n_q    <= mode_to_limbs(bus.mode);
            i_q    <= '0;
            j_q    <= '0;
            sh_q   <= '0;
            pvld_q <= 1'b0;
            acc_q  <= '0;
          end
        end
        RUN: begin
          sh_q   <= {1'b0, i_q} + {1'b0, j_q};
          pvld_q <= 1'b1;
          // prod_q lags the issued pair by one cycle, so the first RUN cycle adds nothing.
          if (pvld_q) acc_q <= acc_q + addend;
          if (last_j) begin
            j_q <= '0;
            if (!last_i) i_q <= i_q + 2'd1;
          end else begin
            j_q <= j_q + 2'd1;
          end
        end
        FLUSH: begin
          acc_q  <= acc_q + addend;
          pvld_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vp_mult_limb_sequencer.sv
// Scoreboard bench for vp_mult_limb_sequencer: directed operands with
// hand-computed products and latencies, checked by a separate monitor.
import vp_mult_pkg::*;

module tb_vp_mult_limb_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  vp_mult_limb_sequencer_if bus ();

  vp_mult_limb_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RES_W-1:0] res;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   acc_cyc = 0;
  logic ov_prev = 1'b0;

  localparam logic [RES_W-1:0] FULL48_SQ = 96'hFFFFFFFFFFFE000000000001;

  task automatic check(input string name, input logic [RES_W-1:0] act,
                       input logic [RES_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Cycle counter and acceptance timestamp, sampled with pre-edge values.
  always @(posedge clk) begin
    cyc++;
    if (rst_n && bus.in_valid && bus.in_ready) acc_cyc = cyc;
  end

  // Monitor: compares every new result presentation against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      ov_prev = 1'b0;
    end else begin
      if (bus.out_valid && !ov_prev) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got=%0h want=none", bus.result);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", bus.result, e.res);
          check("latency", RES_W'(cyc - acc_cyc), RES_W'(e.lat));
        end
      end
      ov_prev = bus.out_valid;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge with
  // operands scrambled to show they are isolated from the running transaction.
  task automatic send(input logic [1:0] mode, input logic [OP_W-1:0] a,
                      input logic [OP_W-1:0] b, input logic [RES_W-1:0] res,
                      input int lat, input bit push);
    bit ok;
    exp_t e;
    ok = 1'b0;
    if (push) begin
      e.res = res;
      e.lat = lat;
      sb.push_back(e);
    end
    bus.in_valid = 1'b1;
    bus.mode     = mode;
    bus.a        = a;
    bus.b        = b;
    for (int k = 0; k < 100; k++) begin
      if (bus.in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout("accept");
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.mode     = 2'($urandom);
    bus.a        = {16'($urandom), 32'($urandom)};
    bus.b        = {16'($urandom), 32'($urandom)};
  endtask

  // Waits for the result handshake; returns at the negedge after it.
  task automatic wait_result();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.out_valid && bus.out_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout("result");
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout("out_valid");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.mode      = 2'd0;
    bus.a         = '0;
    bus.b         = '0;
    #12;
    check("rst_in_ready", RES_W'(bus.in_ready), 1);
    check("rst_out_valid", RES_W'(bus.out_valid), 0);
    check("rst_result", bus.result, 0);
    check("rst_busy", RES_W'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(2'd0, 48'h00000000FFFF, 48'h00000000FFFF, 96'hFFFE0001, 2, 1);
    wait_result();
    send(2'd1, 48'h000000010001, 48'h000000010001, 96'h100020001, 5, 1);
    wait_result();
    send(2'd2, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, FULL48_SQ, 10, 1);
    wait_result();
    send(2'd3, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, FULL48_SQ, 10, 1);
    wait_result();
    send(2'd0, 48'hABCD12340002, 48'h567890AB0003, 96'd6, 2, 1);
    wait_result();
    send(2'd1, 48'hFFFF00020003, 48'hFFFF00000002, 96'h40006, 5, 1);
    wait_result();
    send(2'd1, 48'h000012345678, 48'h000000000010, 96'h123456780, 5, 1);
    wait_result();
    send(2'd2, 48'h000100000000, 48'h000100000000, 96'h1_0000_0000_0000_0000, 10, 1);
    wait_result();

    // Back-pressure: result held, new offer ignored until the handshake.
    bus.out_ready = 1'b0;
    send(2'd2, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, FULL48_SQ, 10, 1);
    wait_valid();
    begin
      exp_t e;
      e.res = 96'd63;
      e.lat = 2;
      sb.push_back(e);
    end
    bus.in_valid = 1'b1;
    bus.mode     = 2'd0;
    bus.a        = 48'd7;
    bus.b        = 48'd9;
    for (int k = 0; k < 5; k++) begin
      check("bp_result", bus.result, FULL48_SQ);
      check("bp_in_ready", RES_W'(bus.in_ready), 0);
      check("bp_out_valid", RES_W'(bus.out_valid), 1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", RES_W'(bus.in_ready), 1);
    check("bp_release_out_valid", RES_W'(bus.out_valid), 0);
    send(2'd0, 48'd7, 48'd9, 96'd63, 2, 0);
    wait_result();

    // Reset in the fourth RUN cycle of a 48-bit run.
    send(2'd2, 48'h123456789ABC, 48'hFEDCBA987654, '0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", RES_W'(bus.out_valid), 0);
    check("midrst_in_ready", RES_W'(bus.in_ready), 1);
    check("midrst_result", bus.result, 0);
    check("midrst_busy", RES_W'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(2'd0, 48'd3, 48'd5, 96'd15, 2, 1);
    wait_result();

    repeat (12) @(negedge clk);
    check("scoreboard_drained", RES_W'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
